// File: rtl/score_keeper.sv
// Level-scaled scoring, line/level progression and gravity period for the row clearer.
// Define SCORE_BCD_EN to build the sequential double-dabble converter behind score_bcd.
module score_keeper #(
    parameter int SCORE_W     = 20,
    parameter int LEVEL_LINES = 10,
    parameter int MAX_LEVEL   = 15,
    parameter int BASE_PERIOD = 48,
    parameter int PERIOD_STEP = 3,
    parameter int MIN_PERIOD  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_done,
    input  logic [2:0]         lines_cleared,
    output logic [SCORE_W-1:0] score,
    output logic [13:0]        lines_total,
    output logic [3:0]         level,
    output logic [5:0]         drop_period,
    output logic               score_event,
    output logic               busy,
    output logic [23:0]        score_bcd,
    output logic               bcd_valid
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_UPDATE} state_t;

    localparam logic [SCORE_W+1:0] SCORE_MAX = (SCORE_W+2)'(999999);
    localparam logic [14:0]        LINES_MAX = 15'd9999;
    localparam logic [4:0]         LVL_LINES = 5'(LEVEL_LINES);
    localparam logic [3:0]         LVL_MAX   = 4'(MAX_LEVEL);

    function automatic logic [10:0] base_points(input logic [2:0] n);
        case (n)
            3'd1:    return 11'd40;
            3'd2:    return 11'd100;
            3'd3:    return 11'd300;
            3'd4:    return 11'd1200;
            default: return 11'd0;
        endcase
    endfunction

    state_t             r_state, w_state_next;
    logic               r_done_q, r_pend_valid, r_event;
    logic [2:0]         w_n, w_load_n, r_n, r_pend_n;
    logic               w_req, w_load, w_commit, w_pend_set, w_pend_clr;
    logic [SCORE_W:0]   r_acc;
    logic [10:0]        r_base;
    logic [3:0]         r_cnt, w_cnt_load;
    logic [SCORE_W-1:0] r_score, w_score_next;
    logic [SCORE_W+1:0] w_score_sum;
    logic [13:0]        r_lines_total, w_lines_next;
    logic [14:0]        w_lines_sum;
    logic [4:0]         r_lil, w_lil_sum, w_lil_next;
    logic [3:0]         r_level, w_level_next;
    logic [5:0]         r_drop;
    int                 w_period;

    assign w_n = (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
    assign w_req = clear_done & ~r_done_q & (w_n != 3'd0);

    // NOTE: every variable gets a default first so this block cannot infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_n     = w_n;
        w_commit     = 1'b0;
        w_pend_set   = 1'b0;
        w_pend_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_load       = 1'b1;
                    w_state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (r_cnt == 4'd0) w_state_next = S_UPDATE;
                if (w_req && !r_pend_valid) w_pend_set = 1'b1;
            end
            S_UPDATE: begin
                w_commit = 1'b1;
                if (r_pend_valid) begin
                    w_load       = 1'b1;
                    w_load_n     = r_pend_n;
                    w_pend_clr   = 1'b1;
                    w_state_next = S_ACCUM;
                end else if (w_req) begin
                    w_load       = 1'b1;
                    w_state_next = S_ACCUM;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_score_sum  = {2'b00, r_score} + {1'b0, r_acc};
        w_score_next = (w_score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : w_score_sum[SCORE_W-1:0];
        w_lines_sum  = {1'b0, r_lines_total} + {12'd0, r_n};
        w_lines_next = (w_lines_sum > LINES_MAX) ? LINES_MAX[13:0] : w_lines_sum[13:0];
        w_lil_sum    = r_lil + {2'b00, r_n};
        w_lil_next   = w_lil_sum;
        w_level_next = r_level;
        if (w_lil_sum >= LVL_LINES) begin
            w_lil_next = w_lil_sum - LVL_LINES;
            if (r_level != LVL_MAX) w_level_next = r_level + 4'd1;
        end
        w_period = BASE_PERIOD - PERIOD_STEP * int'(r_level);
        if (w_period < MIN_PERIOD) w_period = MIN_PERIOD;
    end

    // A pending request chained from UPDATE must scale by the level it just produced.
    assign w_cnt_load = w_commit ? w_level_next : r_level;

    // NOTE: clocked state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_q      <= 1'b1;
            r_acc         <= '0;
            r_base        <= '0;
            r_cnt         <= '0;
            r_n           <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_n      <= '0;
            r_score       <= '0;
            r_lines_total <= '0;
            r_lil         <= '0;
            r_level       <= '0;
            r_event       <= 1'b0;
            r_drop        <= 6'(BASE_PERIOD);
        end else begin
            r_done_q <= clear_done;
            r_event  <= w_commit;
            r_drop   <= 6'(w_period);
            if (w_load) begin
                r_acc  <= '0;
                r_base <= base_points(w_load_n);
                r_cnt  <= w_cnt_load;
                r_n    <= w_load_n;
            end else if (r_state == S_ACCUM) begin
                r_acc <= r_acc + (SCORE_W+1)'(r_base);
                if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            end
            if (w_pend_set) begin
                r_pend_valid <= 1'b1;
                r_pend_n     <= w_n;
            end else if (w_pend_clr) begin
                r_pend_valid <= 1'b0;
            end
            if (w_commit) begin
                r_score       <= w_score_next;
                r_lines_total <= w_lines_next;
                r_lil         <= w_lil_next;
                r_level       <= w_level_next;
            end
        end
    end

    assign score       = r_score;
    assign lines_total = r_lines_total;
    assign level       = r_level;
    assign drop_period = r_drop;
    assign score_event = r_event;
    assign busy        = (r_state != S_IDLE);

`ifdef SCORE_BCD_EN
    localparam int BCNT_W = $clog2(SCORE_W + 1);

    function automatic logic [23:0] dabble_adjust(input logic [23:0] v);
        logic [23:0] a;
        a = v;
        for (int d = 0; d < 6; d++) begin
            if (a[4*d +: 4] >= 4'd5) a[4*d +: 4] = a[4*d +: 4] + 4'd3;
        end
        return a;
    endfunction

    logic [SCORE_W-1:0] r_bin;
    logic [23:0]        r_work, r_bcd, w_work_adj, w_work_shift;
    logic [BCNT_W-1:0]  r_bcnt;
    logic               r_bvalid;

    assign w_work_adj   = dabble_adjust(r_work);
    assign w_work_shift = {w_work_adj[22:0], r_bin[SCORE_W-1]};

    // The load cycle performs the first shift, so the result lands SCORE_W cycles after UPDATE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin    <= '0;
            r_work   <= '0;
            r_bcnt   <= '0;
            r_bcd    <= '0;
            r_bvalid <= 1'b1;
        end else if (w_commit) begin
            r_work   <= {23'd0, w_score_next[SCORE_W-1]};
            r_bin    <= w_score_next << 1;
            r_bcnt   <= BCNT_W'(SCORE_W - 1);
            r_bvalid <= 1'b0;
        end else if (r_bcnt != '0) begin
            r_work <= w_work_shift;
            r_bin  <= r_bin << 1;
            r_bcnt <= r_bcnt - 1'b1;
            if (r_bcnt == BCNT_W'(1)) begin
                r_bcd    <= w_work_shift;
                r_bvalid <= 1'b1;
            end
        end
    end

    assign score_bcd = r_bcd;
    assign bcd_valid = r_bvalid;
`else
    assign score_bcd = 24'd0;
    assign bcd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus randomized clears
// compared every cycle against a transaction-timestamp reference model.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_done = 1'b0;
    logic [2:0]  lines_cleared = 3'd0;
    logic [19:0] score;
    logic [13:0] lines_total;
    logic [3:0]  level;
    logic [5:0]  drop_period;
    logic        score_event, busy;
    logic [23:0] score_bcd;
    logic        bcd_valid;

    always #5 clk = ~clk;

    score_keeper dut (
        .clk           (clk),
        .rst           (rst),
        .clear_done    (clear_done),
        .lines_cleared (lines_cleared),
        .score         (score),
        .lines_total   (lines_total),
        .level         (level),
        .drop_period   (drop_period),
        .score_event   (score_event),
        .busy          (busy),
        .score_bcd     (score_bcd),
        .bcd_valid     (bcd_valid)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: expected visible outputs plus one in-flight job described
    // by its start cycle, so its commit cycle is start + 2 + level.
    int m_score, m_lines, m_lil, m_level, m_period, m_event;
    int m_active, m_s, m_l, m_n, m_pend_valid, m_pend_n, m_prev_cd;
    int m_bcd_ready;
    int cyc = 0;

    function automatic int pts(input int n);
        case (n)
            1: return 40;
            2: return 100;
            3: return 300;
            4: return 1200;
            default: return 0;
        endcase
    endfunction

    function automatic int period_of(input int lvl);
        int p;
        p = 48 - 3 * lvl;
        return (p < 3) ? 3 : p;
    endfunction

    function automatic int to_bcd(input int v);
        int r, x;
        r = 0;
        x = v;
        for (int d = 0; d < 6; d++) begin
            r = r | ((x % 10) << (4 * d));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_score = 0; m_lines = 0; m_lil = 0; m_level = 0; m_period = 48; m_event = 0;
        m_active = 0; m_s = 0; m_l = 0; m_n = 0; m_pend_valid = 0; m_pend_n = 0;
        m_prev_cd = 1; m_bcd_ready = 0;
    endtask

    task automatic model_start(input int s, input int n);
        m_active = 1; m_s = s; m_l = m_level; m_n = n;
    endtask

    task automatic model_step(input bit r, input bit cd, input int raw);
        int n, next_period, next_event;
        bit req;
        if (r) begin
            model_reset();
            return;
        end
        n = (raw > 4) ? 4 : raw;
        req = cd && !m_prev_cd && (n != 0);
        m_prev_cd = cd;
        next_period = period_of(m_level);
        next_event = 0;
        if (m_active && cyc == m_s + 2 + m_l) begin
            m_score = m_score + pts(m_n) * (m_l + 1);
            if (m_score > 999999) m_score = 999999;
            m_lines = m_lines + m_n;
            if (m_lines > 9999) m_lines = 9999;
            m_lil = m_lil + m_n;
            if (m_lil >= 10) begin
                m_lil = m_lil - 10;
                if (m_level < 15) m_level++;
            end
            next_event = 1;
            m_bcd_ready = cyc + 20;
            if (m_pend_valid != 0) begin
                model_start(cyc, m_pend_n);
                m_pend_valid = 0;
            end else if (req) begin
                model_start(cyc, n);
            end else begin
                m_active = 0;
            end
        end else if (m_active != 0) begin
            if (req && m_pend_valid == 0) begin
                m_pend_valid = 1;
                m_pend_n = n;
            end
        end else if (req) begin
            model_start(cyc, n);
        end
        m_period = next_period;
        m_event = next_event;
    endtask

    task automatic compare_all();
        check("score", 32'(score), m_score);
        check("lines_total", 32'(lines_total), m_lines);
        check("level", 32'(level), m_level);
        check("drop_period", 32'(drop_period), m_period);
        check("score_event", 32'(score_event), m_event);
        check("busy", 32'(busy), (m_active != 0 && cyc > m_s) ? 1 : 0);
`ifdef SCORE_BCD_EN
        check("bcd_valid", 32'(bcd_valid), (cyc >= m_bcd_ready) ? 1 : 0);
        if (cyc >= m_bcd_ready) check("score_bcd", 32'(score_bcd), to_bcd(m_score));
`else
        check("bcd_valid_off", 32'(bcd_valid), 0);
        check("score_bcd_off", 32'(score_bcd), 0);
`endif
    endtask

    task automatic tick(input bit r, input bit cd, input int lc);
        @(negedge clk);
        compare_all();
        rst = r;
        clear_done = cd;
        lines_cleared = 3'(lc);
        model_step(r, cd, lc);
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick(1'b0, 1'b0, 0);
    endtask

    task automatic clr(input int n);
        tick(1'b0, 1'b0, n);
        tick(1'b0, 1'b1, n);
    endtask

    task automatic do_reset(input int k);
        for (int i = 0; i < k; i++) tick(1'b1, 1'b0, 0);
    endtask

    initial begin
        bit cd_r;
        model_reset();

        // Single 1-line clear with clear_done held high afterwards.
        do_reset(3);
        idle(2);
        clr(1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1);
        check("first_event_T3", 32'(score_event), 1);
        check("first_score", 32'(score), 40);
        idle(3);

        // Five 4-line clears reach level 2, then a 2-line clear scores 300.
        do_reset(2);
        for (int k = 0; k < 5; k++) begin
            clr(4);
            idle(8);
        end
        check("level_after_20", 32'(level), 2);
        clr(2);
        idle(8);
        check("score_8700", 32'(score), 8700);
        check("period_l2", 32'(drop_period), 42);

        // Second edge during ACCUM goes pending; third edge in UPDATE is dropped.
        clr(1);
        clr(2);
        clr(3);
        idle(12);
        check("pend_score", 32'(score), 9120);
        check("pend_lines", 32'(lines_total), 25);

        // Zero-line edge and clear_done held across reset release: no request.
        clr(0);
        idle(4);
        check("zero_lines_score", 32'(score), 9120);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 3);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 3);
        check("held_cd_lines", 32'(lines_total), 0);

        // Reset mid-ACCUM aborts the request.
        for (int k = 0; k < 5; k++) begin
            clr(4);
            idle(8);
        end
        clr(3);
        idle(2);
        tick(1'b1, 1'b0, 0);
        idle(6);
        check("abort_score", 32'(score), 0);
        check("abort_level", 32'(level), 0);

        // Randomized clears, counts and occasional resets.
        cd_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) cd_r = ~cd_r;
            tick(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0, cd_r, int'($urandom_range(0, 7)));
        end

        // Long run of 4-line clears drives level to its ceiling and score to saturation.
        do_reset(2);
        for (int k = 0; k < 100; k++) begin
            clr(4 + int'($urandom_range(0, 3)));
            idle(18);
        end
        check("sat_score", 32'(score), 999999);
        check("sat_level", 32'(level), 15);
        check("sat_period", 32'(drop_period), 3);
        idle(25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
